// File: rtl/ren_pkg.sv
// ren_pkg: edge/tile types, tile geometry and setup FSM states shared by
// ren_tri_setup and ren_rasterizer.
package ren_pkg;

    localparam int COORD_W   = 16;
    localparam int TILE_LOG2 = 3;
    localparam int TILE_SIZE = 1 << TILE_LOG2;
    // Rasterizer steps pixels in 4-bit sub-pixel fixed point.
    localparam int FP_FRAC_W   = 4;
    localparam int fpTILE_SIZE = TILE_SIZE << FP_FRAC_W;

    typedef struct packed {
        logic signed [COORD_W:0]   a;
        logic signed [COORD_W:0]   b;
        logic signed [2*COORD_W:0] c;
    } edge_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] size;
    } tile_t;

    typedef struct packed {
        edge_t e0;
        edge_t e1;
        edge_t e2;
        tile_t tile;
    } tile_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EMIT
    } setup_state_t;

endpackage

// File: rtl/ren_setup_fifo.sv
// ren_setup_fifo: synchronous first-word fall-through FIFO with registered
// full/empty; a push while full is dropped even if a pop happens that cycle.
module ren_setup_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d   = (count_d == (AW+1)'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/ren_tri_setup.sv
// ren_tri_setup: edge equations + tile bbox for one triangle, then walks the box
// pushing one entry per tile into a FWFT FIFO. REN_BACKFACE_CULL_EN drops CW triangles.
module ren_tri_setup
    import ren_pkg::edge_t, ren_pkg::tile_t, ren_pkg::tile_entry_t, ren_pkg::setup_state_t,
           ren_pkg::ST_IDLE, ren_pkg::ST_SETUP, ren_pkg::ST_EMIT;
#(
    parameter int COORD_W    = 16,
    parameter int TILE_LOG2  = 3,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [COORD_W-1:0] i_v0_x,
    input  logic [COORD_W-1:0] i_v0_y,
    input  logic [COORD_W-1:0] i_v1_x,
    input  logic [COORD_W-1:0] i_v1_y,
    input  logic [COORD_W-1:0] i_v2_x,
    input  logic [COORD_W-1:0] i_v2_y,
    input  logic               i_fifo_read,
    output logic               o_empty,
    output edge_t              o_e0_edge,
    output edge_t              o_e1_edge,
    output edge_t              o_e2_edge,
    output tile_t              o_tile,
    output logic               o_drop,
    output logic               o_busy
);

    localparam int CW2   = 2 * COORD_W;
    localparam int TSIZE = 1 << TILE_LOG2;
    localparam logic [COORD_W-1:0]        TSTEP = COORD_W'(TSIZE);
    localparam logic [COORD_W-1:0]        TMASK = ~COORD_W'(TSIZE - 1);
    localparam logic signed [COORD_W-1:0] XMAX  = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] YMAX  = COORD_W'(SCREEN_H - 1);
    localparam int EW = $bits(tile_entry_t);

    setup_state_t              state_q, state_d;
    logic signed [COORD_W-1:0] vx_q [3], vx_d [3], vy_q [3], vy_d [3];
    edge_t                     e_q [3], e_d [3];
    logic [COORD_W-1:0]        bbx_min_q, bbx_min_d, last_cx_q, last_cx_d, last_cy_q, last_cy_d;
    logic [COORD_W-1:0]        cx_q, cx_d, cy_q, cy_d;
    logic                      drop_q, drop_d;

    logic signed [CW2:0]       vxe [3], vye [3], c_s [3];
    logic signed [COORD_W:0]   a_s [3], b_s [3];
    logic signed [CW2+2:0]     area2;
    logic signed [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0]        bx0, bx1, by0, by1;
    logic                      off_screen, reject, neg;

    logic                      push, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    tile_entry_t               push_entry, head;
    logic [EW-1:0]             fifo_rdata;

    function automatic logic signed [COORD_W-1:0] min3(input logic signed [COORD_W-1:0] p, q, r);
        logic signed [COORD_W-1:0] m;
        m = (p < q) ? p : q;
        return (r < m) ? r : m;
    endfunction

    function automatic logic signed [COORD_W-1:0] max3(input logic signed [COORD_W-1:0] p, q, r);
        logic signed [COORD_W-1:0] m;
        m = (p > q) ? p : q;
        return (r > m) ? r : m;
    endfunction

    // Edge coefficients at full precision from the latched vertices.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            vxe[i] = {{(COORD_W+1){vx_q[i][COORD_W-1]}}, vx_q[i]};
            vye[i] = {{(COORD_W+1){vy_q[i][COORD_W-1]}}, vy_q[i]};
        end
        for (int i = 0; i < 3; i++) begin
            a_s[i] = vye[i][COORD_W:0] - vye[(i+1)%3][COORD_W:0];
            b_s[i] = vxe[(i+1)%3][COORD_W:0] - vxe[i][COORD_W:0];
            c_s[i] = vxe[i] * vye[(i+1)%3] - vxe[(i+1)%3] * vye[i];
        end
        area2 = {{2{c_s[0][CW2]}}, c_s[0]} + {{2{c_s[1][CW2]}}, c_s[1]}
              + {{2{c_s[2][CW2]}}, c_s[2]};
    end

    always_comb begin
        xmin = min3(vx_q[0], vx_q[1], vx_q[2]);
        xmax = max3(vx_q[0], vx_q[1], vx_q[2]);
        ymin = min3(vy_q[0], vy_q[1], vy_q[2]);
        ymax = max3(vy_q[0], vy_q[1], vy_q[2]);
        off_screen = (xmax < 0) || (ymax < 0) || (xmin > XMAX) || (ymin > YMAX);
        bx0 = (xmin < 0) ? '0 : xmin;
        by0 = (ymin < 0) ? '0 : ymin;
        bx1 = (xmax > XMAX) ? XMAX : xmax;
        by1 = (ymax > YMAX) ? YMAX : ymax;
        bx0 = bx0 & TMASK;
        by0 = by0 & TMASK;
`ifdef REN_BACKFACE_CULL_EN
        reject = (area2 == '0) || off_screen || area2[CW2+2];
        neg    = 1'b0;
`else
        reject = (area2 == '0) || off_screen;
        neg    = area2[CW2+2];
`endif
    end

    always_comb begin
        state_d   = state_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        e_d       = e_q;
        bbx_min_d = bbx_min_q;
        last_cx_d = last_cx_q;
        last_cy_d = last_cy_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        drop_d    = 1'b0;
        push      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    vx_d[0] = i_v0_x; vy_d[0] = i_v0_y;
                    vx_d[1] = i_v1_x; vy_d[1] = i_v1_y;
                    vx_d[2] = i_v2_x; vy_d[2] = i_v2_y;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (reject) begin
                    drop_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    // Clockwise input is flipped so E>=0 always means inside.
                    for (int i = 0; i < 3; i++) begin
                        e_d[i].a = neg ? -a_s[i] : a_s[i];
                        e_d[i].b = neg ? -b_s[i] : b_s[i];
                        e_d[i].c = neg ? -c_s[i] : c_s[i];
                    end
                    bbx_min_d = bx0;
                    last_cx_d = bx1 & TMASK;
                    last_cy_d = by1 & TMASK;
                    cx_d      = bx0;
                    cy_d      = by0;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (!fifo_full) begin
                    push = 1'b1;
                    if (cx_q >= last_cx_q) begin
                        cx_d = bbx_min_q;
                        cy_d = cy_q + TSTEP;
                        if (cy_q >= last_cy_q) state_d = ST_IDLE;
                    end else begin
                        cx_d = cx_q + TSTEP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bbx_min_q <= '0;
            last_cx_q <= '0;
            last_cy_q <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
                e_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            bbx_min_q <= bbx_min_d;
            last_cx_q <= last_cx_d;
            last_cy_q <= last_cy_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            drop_q    <= drop_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            e_q       <= e_d;
        end
    end

    always_comb begin
        push_entry.e0        = e_q[0];
        push_entry.e1        = e_q[1];
        push_entry.e2        = e_q[2];
        push_entry.tile.x    = cx_q;
        push_entry.tile.y    = cy_q;
        push_entry.tile.size = TSTEP;
    end

    ren_setup_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (i_fifo_read),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head      = fifo_rdata;
    assign o_e0_edge = head.e0;
    assign o_e1_edge = head.e1;
    assign o_e2_edge = head.e2;
    assign o_tile    = head.tile;
    assign o_empty   = fifo_empty;
    assign o_ready   = (state_q == ST_IDLE);
    assign o_drop    = drop_q;
    assign o_busy    = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
